// File: rtl/prga_decrypt.sv
// RC4 pseudo-random generation and decryption stage: walks i/j over the permuted S,
// swaps entries, and XORs each keystream byte with a ciphertext byte from the ROM.
module prga_decrypt #(
    parameter int MSG_LEN  = 32,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       finish,
    output logic       busy,
    output logic       key_bad,
    output logic [7:0] s_addr,
    output logic [7:0] s_wr_data,
    output logic       s_rd_start,
    input  logic       s_rd_done,
    input  logic [7:0] s_rd_data,
    output logic       s_wr_start,
    input  logic       s_wr_done,
    output logic [7:0] enc_addr,
    output logic       enc_rd_start,
    input  logic       enc_rd_done,
    input  logic [7:0] enc_rd_data,
    output logic [7:0] dec_addr,
    output logic [7:0] dec_wr_data,
    output logic       dec_wr_start,
    input  logic       dec_wr_done
);

    typedef enum logic [4:0] {
        IDLE, INC_I, RD_SI, WAIT_SI, CALC_J, SET_J, RD_SJ, WAIT_SJ,
        WR_SI, WAIT_WR_SI, WR_SJ, WAIT_WR_SJ, SET_F, RD_F, WAIT_F,
        RD_ENC, WAIT_ENC, CHECK, WR_DEC, WAIT_DEC, NEXT_K, DONE
    } state_t;

    localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [7:0] si_q, si_d, sj_q, sj_d, f_q, f_d, c_q, c_d;
    logic [7:0] s_addr_q, s_addr_d, s_wr_data_q, s_wr_data_d;
    logic [7:0] enc_addr_q, enc_addr_d, dec_addr_q, dec_addr_d, dec_wr_data_q, dec_wr_data_d;
    logic       s_rd_start_q, s_rd_start_d, s_wr_start_q, s_wr_start_d;
    logic       enc_rd_start_q, enc_rd_start_d, dec_wr_start_q, dec_wr_start_d;
    logic       finish_q, finish_d, busy_q, busy_d, key_bad_q, key_bad_d;
    logic [7:0] p_s;

    // Acceptable plaintext: lowercase letters and space only.
    function automatic logic is_text(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7a)) || (b == 8'h20);
    endfunction

    // Next-state, datapath updates, and strobes decoded from the state being entered.
    always_comb begin
        state_d        = state_q;
        i_d            = i_q;
        j_d            = j_q;
        k_d            = k_q;
        si_d           = si_q;
        sj_d           = sj_q;
        f_d            = f_q;
        c_d            = c_q;
        s_addr_d       = s_addr_q;
        s_wr_data_d    = s_wr_data_q;
        enc_addr_d     = enc_addr_q;
        dec_addr_d     = dec_addr_q;
        dec_wr_data_d  = dec_wr_data_q;
        key_bad_d      = key_bad_q;
        p_s            = f_q ^ c_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    i_d       = 8'd0;
                    j_d       = 8'd0;
                    k_d       = 8'd0;
                    key_bad_d = 1'b0;
                    state_d   = INC_I;
                end else begin
                    state_d = IDLE;
                end
            end
            INC_I: begin
                i_d      = i_q + 8'd1;
                s_addr_d = i_q + 8'd1;
                state_d  = RD_SI;
            end
            RD_SI:   state_d = WAIT_SI;
            WAIT_SI: begin
                if (s_rd_done) begin
                    si_d    = s_rd_data;
                    state_d = CALC_J;
                end else begin
                    state_d = WAIT_SI;
                end
            end
            CALC_J: begin
                j_d     = j_q + si_q;
                state_d = SET_J;
            end
            SET_J: begin
                s_addr_d = j_q;
                state_d  = RD_SJ;
            end
            RD_SJ:   state_d = WAIT_SJ;
            // Address and data for the first swap write are staged as s[j] arrives.
            WAIT_SJ: begin
                if (s_rd_done) begin
                    sj_d        = s_rd_data;
                    s_addr_d    = i_q;
                    s_wr_data_d = s_rd_data;
                    state_d     = WR_SI;
                end else begin
                    state_d = WAIT_SJ;
                end
            end
            WR_SI:      state_d = WAIT_WR_SI;
            WAIT_WR_SI: begin
                if (s_wr_done) begin
                    s_addr_d    = j_q;
                    s_wr_data_d = si_q;
                    state_d     = WR_SJ;
                end else begin
                    state_d = WAIT_WR_SI;
                end
            end
            WR_SJ:      state_d = WAIT_WR_SJ;
            WAIT_WR_SJ: begin
                if (s_wr_done) begin
                    state_d = SET_F;
                end else begin
                    state_d = WAIT_WR_SJ;
                end
            end
            SET_F: begin
                s_addr_d = si_q + sj_q;
                state_d  = RD_F;
            end
            RD_F:   state_d = WAIT_F;
            WAIT_F: begin
                if (s_rd_done) begin
                    f_d        = s_rd_data;
                    enc_addr_d = k_q;
                    state_d    = RD_ENC;
                end else begin
                    state_d = WAIT_F;
                end
            end
            RD_ENC:   state_d = WAIT_ENC;
            WAIT_ENC: begin
                if (enc_rd_done) begin
                    c_d     = enc_rd_data;
                    state_d = CHECK;
                end else begin
                    state_d = WAIT_ENC;
                end
            end
            CHECK: begin
                if (CHECK_EN && !is_text(p_s)) begin
                    key_bad_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    dec_addr_d    = k_q;
                    dec_wr_data_d = p_s;
                    state_d       = WR_DEC;
                end
            end
            WR_DEC:   state_d = WAIT_DEC;
            WAIT_DEC: begin
                if (dec_wr_done) begin
                    state_d = NEXT_K;
                end else begin
                    state_d = WAIT_DEC;
                end
            end
            NEXT_K: begin
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 8'd1;
                    state_d = INC_I;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        s_rd_start_d   = (state_d == RD_SI) || (state_d == RD_SJ) || (state_d == RD_F);
        s_wr_start_d   = (state_d == WR_SI) || (state_d == WR_SJ);
        enc_rd_start_d = (state_d == RD_ENC);
        dec_wr_start_d = (state_d == WR_DEC);
        finish_d       = (state_d == DONE);
        busy_d         = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            i_q            <= 8'd0;
            j_q            <= 8'd0;
            k_q            <= 8'd0;
            si_q           <= 8'd0;
            sj_q           <= 8'd0;
            f_q            <= 8'd0;
            c_q            <= 8'd0;
            s_addr_q       <= 8'd0;
            s_wr_data_q    <= 8'd0;
            enc_addr_q     <= 8'd0;
            dec_addr_q     <= 8'd0;
            dec_wr_data_q  <= 8'd0;
            s_rd_start_q   <= 1'b0;
            s_wr_start_q   <= 1'b0;
            enc_rd_start_q <= 1'b0;
            dec_wr_start_q <= 1'b0;
            finish_q       <= 1'b0;
            busy_q         <= 1'b0;
            key_bad_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            i_q            <= i_d;
            j_q            <= j_d;
            k_q            <= k_d;
            si_q           <= si_d;
            sj_q           <= sj_d;
            f_q            <= f_d;
            c_q            <= c_d;
            s_addr_q       <= s_addr_d;
            s_wr_data_q    <= s_wr_data_d;
            enc_addr_q     <= enc_addr_d;
            dec_addr_q     <= dec_addr_d;
            dec_wr_data_q  <= dec_wr_data_d;
            s_rd_start_q   <= s_rd_start_d;
            s_wr_start_q   <= s_wr_start_d;
            enc_rd_start_q <= enc_rd_start_d;
            dec_wr_start_q <= dec_wr_start_d;
            finish_q       <= finish_d;
            busy_q         <= busy_d;
            key_bad_q      <= key_bad_d;
        end
    end

    assign finish       = finish_q;
    assign busy         = busy_q;
    assign key_bad      = key_bad_q;
    assign s_addr       = s_addr_q;
    assign s_wr_data    = s_wr_data_q;
    assign s_rd_start   = s_rd_start_q;
    assign s_wr_start   = s_wr_start_q;
    assign enc_addr     = enc_addr_q;
    assign enc_rd_start = enc_rd_start_q;
    assign dec_addr     = dec_addr_q;
    assign dec_wr_data  = dec_wr_data_q;
    assign dec_wr_start = dec_wr_start_q;

endmodule
